// File: rtl/gb_apu_wave_ram.sv
// -----------------------------------------------------------------------------
// gb_apu_wave_ram
//
// 16-byte wave pattern RAM feeding the custom wave channel (Ch 3), with CPU
// byte access at FF30..FF3F.
//
// While the channel is playing, the CPU does not get to choose which byte it
// touches: every access lands on the byte the channel is currently addressing.
// On DMG hardware that access only works during a short window just after the
// channel advances to a new byte. Outside the window, writes are dropped and
// reads return 8'hFF.
//
// Parameters
//   STRICT_DMG    : 1 = gate CPU access with the fetch window while enabled,
//                   0 = CPU access always allowed (CGB behaviour).
//   ACCESS_WINDOW : cycles (1..3) the window stays open after wave_addr moves.
//   RESET_BYTE    : value loaded into every byte on reset.
//
// Ports
//   clk        : system clock, all state on posedge
//   reset      : asynchronous, active-low reset
//   wave_addr  : byte index requested by Ch 3
//   ch_enable  : Ch 3 playing
//   wave_data  : mem[wave_addr], combinational
//   cpu_addr   : CPU byte address
//   cpu_wdata  : CPU write data
//   cpu_wr     : CPU write strobe (single cycle)
//   cpu_rd     : CPU read strobe (single cycle)
//   cpu_rdata  : registered read data, held between reads
//   cpu_rvalid : one-cycle pulse per read, cpu_rdata valid
// -----------------------------------------------------------------------------
module gb_apu_wave_ram #(
    parameter bit          STRICT_DMG    = 1'b1,
    parameter int unsigned ACCESS_WINDOW = 2,
    parameter logic [7:0]  RESET_BYTE    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] wave_addr,
    input  logic       ch_enable,
    output logic [7:0] wave_data,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid
);

    localparam logic [1:0] WIN_LOAD = 2'(ACCESS_WINDOW);

    logic [7:0] r_mem [16];
    logic [3:0] r_wave_addr_q;
    logic [1:0] r_win_cnt;
    logic [7:0] r_rdata;
    logic       r_rvalid;

    logic [3:0] w_eff_addr;
    logic       w_allowed;
    logic       w_wr_en;
    logic [7:0] w_rd_byte;

    // While playing, the channel owns the address lines; the CPU's own
    // address is ignored.
    assign w_eff_addr = ch_enable ? wave_addr : cpu_addr;

    // Decided on the pre-edge count, so a count of 1 still lets the access
    // through on the edge that takes the count to 0.
    assign w_allowed  = !ch_enable || !STRICT_DMG || (r_win_cnt != 2'd0);
    assign w_wr_en    = cpu_wr && w_allowed;
    assign w_rd_byte  = w_allowed ? r_mem[w_eff_addr] : 8'hFF;

    assign wave_data  = r_mem[wave_addr];
    assign cpu_rdata  = r_rdata;
    assign cpu_rvalid = r_rvalid;

    // Pattern storage. Reset clears the whole array, so a reset in the
    // middle of playback also wipes the pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= RESET_BYTE;
            end
        end else if (w_wr_en) begin
            r_mem[w_eff_addr] <= cpu_wdata;
        end
    end

    // Fetch-window tracker. The window opens only when the channel moves to
    // a new byte while enabled. Enabling the channel on an unchanged address
    // does not open it, because the disabled branch keeps the last address
    // in sync. A move while the window is open reloads the count; it does
    // not add to it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wave_addr_q <= 4'h0;
            r_win_cnt     <= 2'd0;
        end else if (!ch_enable) begin
            r_wave_addr_q <= wave_addr;
            r_win_cnt     <= 2'd0;
        end else if (wave_addr != r_wave_addr_q) begin
            r_wave_addr_q <= wave_addr;
            r_win_cnt     <= WIN_LOAD;
        end else if (r_win_cnt != 2'd0) begin
            r_win_cnt     <= r_win_cnt - 2'd1;
        end
    end

    // CPU read port. Data is sampled from the pre-edge contents, so a read
    // and a write to the same byte on the same edge return the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata  <= 8'hFF;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= cpu_rd;
            if (cpu_rd) begin
                r_rdata <= w_rd_byte;
            end
        end
    end

endmodule
